// File: rtl/merge_pkg.sv
// Constants and encodings shared by the sprite motion controller and the pixel merge stage.
package merge_pkg;

    localparam int SPRITE_SIZE = 16;
    localparam int BG_SIZE_X   = 1000;
    localparam int BG_SIZE_Y   = 1000;

    // One-hot boundary-collision codes reported by the merge stage.
    localparam logic [3:0] COL_NONE  = 4'b0000;
    localparam logic [3:0] COL_RIGHT = 4'b0001;
    localparam logic [3:0] COL_LEFT  = 4'b0010;
    localparam logic [3:0] COL_DOWN  = 4'b0100;
    localparam logic [3:0] COL_UP    = 4'b1000;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLE   = 3'd1,
        ST_UPDATE_X = 3'd2,
        ST_UPDATE_Y = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/sprite_motion_axis_step.sv
// One axis of sprite motion: picks a signed step from collision/buttons and saturates into [0, MAX].
module axis_step #(
    parameter int STEP = 2,
    parameter int MAX  = 984
) (
    input  logic [9:0] i_pos,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_bounce_pos,  // hit the high-side wall: forced step toward 0
    input  logic       i_bounce_neg,  // hit the low-side wall: forced step toward MAX
    output logic [9:0] o_next,
    output logic       o_bounced
);

    logic signed [10:0] w_pos;
    logic signed [10:0] w_step;
    logic signed [10:0] w_max;
    logic signed [10:0] w_raw;

    assign w_pos  = signed'({1'b0, i_pos});
    assign w_step = 11'(STEP);
    assign w_max  = 11'(MAX);

    always_comb begin
        w_raw     = w_pos;
        o_bounced = 1'b0;
        if (i_bounce_pos) begin
            w_raw     = w_pos - w_step;
            o_bounced = 1'b1;
        end else if (i_bounce_neg) begin
            w_raw     = w_pos + w_step;
            o_bounced = 1'b1;
        end else if (i_inc && !i_dec) begin
            w_raw = w_pos + w_step;
        end else if (i_dec && !i_inc) begin
            w_raw = w_pos - w_step;
        end

        if (w_raw < 11'sd0) begin
            o_next = 10'd0;
        end else if (w_raw > w_max) begin
            o_next = w_max[9:0];
        end else begin
            o_next = w_raw[9:0];
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite position controller: samples buttons/collision once per frame_tick and steps X then Y.
module sprite_motion
    import merge_pkg::*;
#(
    parameter int SPRITE_SIZE = merge_pkg::SPRITE_SIZE,
    parameter int BG_SIZE_X   = merge_pkg::BG_SIZE_X,
    parameter int BG_SIZE_Y   = merge_pkg::BG_SIZE_Y,
    parameter int START_X     = 492,
    parameter int START_Y     = 492,
    parameter int STEP        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frame_tick,
    input  logic [3:0] i_btn,
    input  logic [3:0] i_collision,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_done,
    output logic       o_bounce,
    output logic       o_overrun,
    output state_t     o_state
);

    localparam int MAX_X = BG_SIZE_X - SPRITE_SIZE;
    localparam int MAX_Y = BG_SIZE_Y - SPRITE_SIZE;

    state_t     r_state;
    state_t     w_next_state;
    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [3:0] r_btn;
    logic [3:0] r_col;
    logic       r_bounce_flag;
    logic       r_overrun;

    logic [9:0] w_next_x;
    logic [9:0] w_next_y;
    logic       w_bounced_x;
    logic       w_bounced_y;

    axis_step #(.STEP(STEP), .MAX(MAX_X)) u_axis_x (
        .i_pos        (r_pos_x),
        .i_inc        (r_btn[BTN_RIGHT]),
        .i_dec        (r_btn[BTN_LEFT]),
        .i_bounce_pos (r_col == COL_RIGHT),
        .i_bounce_neg (r_col == COL_LEFT),
        .o_next       (w_next_x),
        .o_bounced    (w_bounced_x)
    );

    axis_step #(.STEP(STEP), .MAX(MAX_Y)) u_axis_y (
        .i_pos        (r_pos_y),
        .i_inc        (r_btn[BTN_DOWN]),
        .i_dec        (r_btn[BTN_UP]),
        .i_bounce_pos (r_col == COL_DOWN),
        .i_bounce_neg (r_col == COL_UP),
        .o_next       (w_next_y),
        .o_bounced    (w_bounced_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_done       = 1'b0;
        o_bounce     = 1'b0;
        case (r_state)
            ST_IDLE:     if (i_frame_tick) w_next_state = ST_SAMPLE;
            ST_SAMPLE:   w_next_state = ST_UPDATE_X;
            ST_UPDATE_X: w_next_state = ST_UPDATE_Y;
            ST_UPDATE_Y: w_next_state = ST_DONE;
            ST_DONE: begin
                w_next_state = ST_IDLE;
                o_done       = 1'b1;
                o_bounce     = r_bounce_flag;
            end
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x       <= 10'(START_X);
            r_pos_y       <= 10'(START_Y);
            r_btn         <= 4'd0;
            r_col         <= COL_NONE;
            r_bounce_flag <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Ticks that land mid-update are dropped; flag them one cycle later.
            r_overrun <= i_frame_tick && (r_state != ST_IDLE);
            case (r_state)
                ST_SAMPLE: begin
                    r_btn         <= i_btn;
                    r_col         <= i_collision;
                    r_bounce_flag <= 1'b0;
                end
                ST_UPDATE_X: begin
                    r_pos_x <= w_next_x;
                    if (w_bounced_x) r_bounce_flag <= 1'b1;
                end
                ST_UPDATE_Y: begin
                    r_pos_y <= w_next_y;
                    if (w_bounced_y) r_bounce_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pos_x   = r_pos_x;
    assign o_pos_y   = r_pos_y;
    assign o_overrun = r_overrun;
    assign o_state   = r_state;

endmodule

// File: tb/tb_sprite_motion.sv
// Self-checking bench for sprite_motion: directed frame scenarios plus randomized frames against a reference model.
module tb_sprite_motion;
    import merge_pkg::*;

    localparam int STEP  = 2;
    localparam int MAXP  = 984;
    localparam int START = 492;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_frame_tick = 1'b0;
    logic [3:0] i_btn = 4'd0;
    logic [3:0] i_collision = 4'd0;
    logic [9:0] o_pos_x;
    logic [9:0] o_pos_y;
    logic       o_done;
    logic       o_bounce;
    logic       o_overrun;
    state_t     o_state;

    int checks = 0;
    int errors = 0;
    int mx;
    int my;

    // Observations for cycles n..n+5 of the most recent frame.
    logic [9:0] ox [6];
    logic [9:0] oy [6];
    logic       od [6];
    logic       ob [6];
    logic       oo [6];
    state_t     os [6];

    sprite_motion dut (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (i_frame_tick),
        .i_btn        (i_btn),
        .i_collision  (i_collision),
        .o_pos_x      (o_pos_x),
        .o_pos_y      (o_pos_y),
        .o_done       (o_done),
        .o_bounce     (o_bounce),
        .o_overrun    (o_overrun),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    // Reference: collision forces a step away from the wall, else net button direction, then clamp.
    function automatic int axis_model(input int p, input bit inc, input bit dec,
                                      input bit hit_hi, input bit hit_lo, output bit bnc);
        int d;
        bnc = hit_hi || hit_lo;
        if (hit_hi)      d = -STEP;
        else if (hit_lo) d = STEP;
        else             d = (inc ? STEP : 0) - (dec ? STEP : 0);
        p = p + d;
        if (p < 0)    p = 0;
        if (p > MAXP) p = MAXP;
        return p;
    endfunction

    // Runs cycles n..n+5: tick at k=0 (and at k=extra), btn b for k<=1 then b_late, reset at k=rst_at.
    task automatic do_frame(input logic [3:0] b, input logic [3:0] b_late, input logic [3:0] c,
                            input int extra, input int rst_at);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            ox[k] = o_pos_x;
            oy[k] = o_pos_y;
            od[k] = o_done;
            ob[k] = o_bounce;
            oo[k] = o_overrun;
            os[k] = o_state;
            i_frame_tick = (k == 0) || (k == extra);
            i_btn        = (k <= 1) ? b : b_late;
            i_collision  = (k <= 1) ? c : 4'($urandom_range(0, 15));
            reset        = (k == rst_at);
        end
        i_frame_tick = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (o_pos_x !== 10'(START) || o_pos_y !== 10'(START) || o_done !== 1'b0 ||
            o_bounce !== 1'b0 || o_overrun !== 1'b0 || o_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d done=%b bounce=%b ovr=%b st=%0d required 492 492 0 0 0 IDLE",
                     o_pos_x, o_pos_y, o_done, o_bounce, o_overrun, o_state);
        end
        mx = START;
        my = START;
    endtask

    task automatic test_move_right;
        do_frame(4'b0001, 4'b0001, COL_NONE, -1, -1);
        checks++;
        if (ox[2] !== 10'd492 || ox[3] !== 10'd494) begin
            errors++;
            $display("FAIL move_right_x: x@n+2=%0d x@n+3=%0d required 492 494", ox[2], ox[3]);
        end
        checks++;
        if (oy[4] !== 10'd492) begin
            errors++;
            $display("FAIL move_right_y: y=%0d required 492", oy[4]);
        end
        checks++;
        if ({od[0], od[1], od[2], od[3], od[4], od[5]} !== 6'b000010 || ob[4] !== 1'b0) begin
            errors++;
            $display("FAIL move_right_done: done n..n+5=%b%b%b%b%b%b bounce=%b required 000010 0",
                     od[0], od[1], od[2], od[3], od[4], od[5], ob[4]);
        end
        checks++;
        if (os[1] !== ST_SAMPLE || os[2] !== ST_UPDATE_X || os[5] !== ST_IDLE) begin
            errors++;
            $display("FAIL move_right_states: %0d %0d %0d required SAMPLE UPDATE_X IDLE", os[1], os[2], os[5]);
        end
        mx = 494;
    endtask

    task automatic test_sampled_copy;
        do_frame(4'b0011, 4'b0000, COL_NONE, -1, -1);
        checks++;
        if (ox[5] !== 10'(mx) || oy[5] !== 10'(my)) begin
            errors++;
            $display("FAIL both_buttons: x=%0d y=%0d required %0d %0d", ox[5], oy[5], mx, my);
        end
        do_frame(4'b0001, 4'b0000, COL_NONE, -1, -1);
        mx = mx + STEP;
        checks++;
        if (ox[5] !== 10'(mx)) begin
            errors++;
            $display("FAIL sampled_copy: x=%0d required %0d", ox[5], mx);
        end
    endtask

    task automatic test_clamp(input logic [3:0] b, input int frames, input int ex_end, input int ey_end);
        int ex;
        int ey;
        bit bx;
        bit by;
        for (int f = 0; f < frames; f++) begin
            do_frame(b, b, COL_NONE, -1, -1);
            ex = axis_model(mx, b[BTN_RIGHT], b[BTN_LEFT], 1'b0, 1'b0, bx);
            ey = axis_model(my, b[BTN_DOWN], b[BTN_UP], 1'b0, 1'b0, by);
            checks++;
            if (ox[3] !== 10'(ex) || oy[4] !== 10'(ey)) begin
                errors++;
                $display("FAIL clamp_frame%0d: x=%0d y=%0d required %0d %0d", f, ox[3], oy[4], ex, ey);
            end
            mx = ex;
            my = ey;
        end
        checks++;
        if (o_pos_x !== 10'(ex_end) || o_pos_y !== 10'(ey_end)) begin
            errors++;
            $display("FAIL clamp_end: x=%0d y=%0d required %0d %0d", o_pos_x, o_pos_y, ex_end, ey_end);
        end
    endtask

    task automatic test_bounce;
        // Entered with x=984, y=0.
        do_frame(4'b0001, 4'b0001, COL_RIGHT, -1, -1);
        checks++;
        if (ox[3] !== 10'd982 || ob[4] !== 1'b1 || od[4] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_right: x=%0d bounce=%b done=%b required 982 1 1", ox[3], ob[4], od[4]);
        end
        checks++;
        if (ob[3] !== 1'b0 || ob[5] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_window: bounce@n+3=%b @n+5=%b required 0 0", ob[3], ob[5]);
        end
        mx = 982;
        do_frame(4'b1000, 4'b1000, COL_UP, -1, -1);
        checks++;
        if (oy[4] !== 10'd2 || ob[4] !== 1'b1 || ox[4] !== 10'd982) begin
            errors++;
            $display("FAIL bounce_top: y=%0d bounce=%b x=%0d required 2 1 982", oy[4], ob[4], ox[4]);
        end
        my = 2;
    endtask

    task automatic test_overrun_and_reset;
        do_frame(4'b0001, 4'b0001, COL_NONE, 2, -1);
        checks++;
        if ({oo[1], oo[2], oo[3], oo[4], oo[5]} !== 5'b00100) begin
            errors++;
            $display("FAIL overrun_pulse: ovr n+1..n+5=%b%b%b%b%b required 00100", oo[1], oo[2], oo[3], oo[4], oo[5]);
        end
        mx = mx + STEP;
        checks++;
        if (ox[5] !== 10'(mx) || os[5] !== ST_IDLE) begin
            errors++;
            $display("FAIL overrun_single_update: x=%0d st=%0d required %0d IDLE", ox[5], os[5], mx);
        end
        // Confirm no second update follows from the dropped tick.
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (o_pos_x !== 10'(mx) || o_state !== ST_IDLE) begin
            errors++;
            $display("FAIL overrun_no_second: x=%0d st=%0d required %0d IDLE", o_pos_x, o_state, mx);
        end
        do_frame(4'b0101, 4'b0101, COL_NONE, -1, 3);
        checks++;
        if (ox[4] !== 10'(START) || oy[4] !== 10'(START) || os[4] !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid: x=%0d y=%0d st=%0d required 492 492 IDLE", ox[4], oy[4], os[4]);
        end
        checks++;
        if (od[3] !== 1'b0 || od[4] !== 1'b0 || od[5] !== 1'b0 || ob[4] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: done n+3..n+5=%b%b%b bounce=%b required 000 0", od[3], od[4], od[5], ob[4]);
        end
        mx = START;
        my = START;
    endtask

    task automatic test_random(input int frames);
        logic [3:0] col_tab [6];
        logic [3:0] b;
        logic [3:0] c;
        int ex;
        int ey;
        int extra;
        bit bx;
        bit by;
        col_tab[0] = COL_NONE;
        col_tab[1] = COL_RIGHT;
        col_tab[2] = COL_LEFT;
        col_tab[3] = COL_DOWN;
        col_tab[4] = COL_UP;
        col_tab[5] = COL_NONE;
        for (int f = 0; f < frames; f++) begin
            b = 4'($urandom_range(0, 15));
            c = col_tab[$urandom_range(0, 5)];
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_frame(b, 4'($urandom_range(0, 15)), c, extra, -1);
            ex = axis_model(mx, b[BTN_RIGHT], b[BTN_LEFT], c == COL_RIGHT, c == COL_LEFT, bx);
            ey = axis_model(my, b[BTN_DOWN], b[BTN_UP], c == COL_DOWN, c == COL_UP, by);
            checks++;
            if (ox[2] !== 10'(mx) || ox[3] !== 10'(ex) || oy[3] !== 10'(my) || oy[4] !== 10'(ey)) begin
                errors++;
                $display("FAIL rand_pos%0d: x=%0d,%0d y=%0d,%0d required %0d,%0d %0d,%0d (btn=%b col=%b)",
                         f, ox[2], ox[3], oy[3], oy[4], mx, ex, my, ey, b, c);
            end
            checks++;
            if (od[3] !== 1'b0 || od[4] !== 1'b1 || od[5] !== 1'b0 || ob[4] !== (bx | by)) begin
                errors++;
                $display("FAIL rand_done%0d: done=%b%b%b bounce=%b required 010 %b", f, od[3], od[4], od[5], ob[4], bx | by);
            end
            for (int j = 1; j < 6; j++) begin
                checks++;
                if (oo[j] !== (j == extra + 1)) begin
                    errors++;
                    $display("FAIL rand_overrun%0d_k%0d: ovr=%b required %b (extra=%0d)", f, j, oo[j], j == extra + 1, extra);
                end
            end
            mx = ex;
            my = ey;
        end
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_sampled_copy();
        test_clamp(4'b1001, 250, MAXP, 0);
        test_bounce();
        test_overrun_and_reset();
        test_clamp(4'b0110, 250, 0, MAXP);
        test_random(300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
